farm_top: RTL and testbench



---
 rtl/farm_top.sv | 374 +++++++++++++++++++++++++++++++++++++
 tb/tb_farm_top.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/farm_top.sv
// FARM multicycle RV32I-subset core: 4-state control, fetch, ROM, decode/RF, ALU.
// Optional feature macro: FARM_BRANCH_EN enables BEQ/BNE. Without it, branches are NOPs.

package farm_pkg;
  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    DECODE    = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
endpackage

module farm_cg (
  input  logic clk,
  input  logic rst_n,
  output logic fetch_en,
  output logic decode_en,
  output logic exec_en,
  output logic wb_en
);
  import farm_pkg::*;

  state_t state, state_nxt;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    state_nxt = FETCH;
    fetch_en  = 1'b0;
    decode_en = 1'b0;
    exec_en   = 1'b0;
    wb_en     = 1'b0;
    case (state)
      FETCH:     begin state_nxt = DECODE;    fetch_en  = 1'b1; end
      DECODE:    begin state_nxt = EXECUTE;   decode_en = 1'b1; end
      EXECUTE:   begin state_nxt = WRITEBACK; exec_en   = 1'b1; end
      WRITEBACK: begin state_nxt = FETCH;     wb_en     = 1'b1; end
      default:   state_nxt = FETCH;
    endcase
  end
endmodule

module farm_iag #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_we,
  input  logic [31:0] pc_nxt,
  output logic [31:0] pc
);
  logic [31:0] PC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     PC <= RESET_PC;
    else if (pc_we) PC <= pc_nxt;
  end

  assign pc = PC;
endmodule

module farm_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        pc_we,
  input  logic [31:0] pc_nxt,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] ir
);
  logic [31:0] IR;

  farm_iag #(.RESET_PC(RESET_PC)) iag (
    .clk    (clk),
    .rst_n  (rst_n),
    .pc_we  (pc_we),
    .pc_nxt (pc_nxt),
    .pc     (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        IR <= '0;
    else if (fetch_en) IR <= imem_data;
  end

  assign ir = IR;
endmodule

module farm_imem #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   data
);
  // Contents are loaded from outside the design and survive reset.
  logic [31:0] mem [DEPTH];

  assign data = mem[addr];
endmodule

module farm_pmi_unit #(
  parameter int IMEM_DEPTH = 64,
  parameter int AW         = $clog2(IMEM_DEPTH)
) (
  input  logic [AW-1:0] word_addr,
  output logic [31:0]   rdata
);
  farm_imem #(.DEPTH(IMEM_DEPTH), .AW(AW)) imem (
    .addr (word_addr),
    .data (rdata)
  );
endmodule

module farm_rf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] regs [32];

  // NOTE: the register file is architecturally zeroed by reset, so it is reset as flops;
  // the instruction ROM is deliberately not reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  // x0 is never written, so it always reads zero.
  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];

  // Debug aid for simulation: prints RF[first..last], one register per line.
  task automatic dump(input int first, input int last);
    for (int i = first; i <= last; i++) $display("x%0d = %08h", i, regs[i]);
  endtask
endmodule

module farm_dec_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        decode_en,
  input  logic [31:0] ir,
  input  logic        rf_we,
  input  logic [4:0]  rf_wa,
  input  logic [31:0] rf_wd,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [31:0] imm
);
  import farm_pkg::*;

  logic [31:0] rs1_val, rs2_val, imm_sel;

  farm_rf RF (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (ir[19:15]),
    .ra2   (ir[24:20]),
    .rd1   (rs1_val),
    .rd2   (rs2_val),
    .we    (rf_we),
    .wa    (rf_wa),
    .wd    (rf_wd)
  );

  always_comb begin
    imm_sel = {{20{ir[31]}}, ir[31:20]};
    case (ir[6:0])
      OP_STORE:         imm_sel = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OP_BRANCH:        imm_sel = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm_sel = {ir[31:12], 12'b0};
      OP_JAL:           imm_sel = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:          imm_sel = {{20{ir[31]}}, ir[31:20]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a   <= '0;
      b   <= '0;
      imm <= '0;
    end else if (decode_en) begin
      a   <= rs1_val;
      b   <= rs2_val;
      imm <= imm_sel;
    end
  end
endmodule

module farm_top #(
  parameter int          IMEM_DEPTH = 64,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] ins,
  output logic [31:0] ret_ad
);
  import farm_pkg::*;

  localparam int IMEM_AW = $clog2(IMEM_DEPTH);

  logic        fetch_en, decode_en, exec_en, wb_en;
  logic [31:0] pc, pc_nxt, pc_plus4, ir, imem_data;
  logic [31:0] a, b, imm;
  logic [31:0] alu_res, alu_out;
  logic        rd_write, is_jal, is_jalr, br_cond, br_taken;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;

  assign opcode   = ir[6:0];
  assign funct3   = ir[14:12];
  assign funct7   = ir[31:25];
  assign pc_plus4 = pc + 32'd4;
  assign ins      = ir;

  farm_cg cg (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_en  (fetch_en),
    .decode_en (decode_en),
    .exec_en   (exec_en),
    .wb_en     (wb_en)
  );

  farm_fetch_unit #(.RESET_PC(RESET_PC)) farm_fetch (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_en  (fetch_en),
    .pc_we     (wb_en),
    .pc_nxt    (pc_nxt),
    .imem_data (imem_data),
    .pc        (pc),
    .ir        (ir)
  );

  farm_pmi_unit #(.IMEM_DEPTH(IMEM_DEPTH), .AW(IMEM_AW)) farm_pmi (
    .word_addr (pc[IMEM_AW+1:2]),
    .rdata     (imem_data)
  );

  farm_dec_unit farm_dec (
    .clk       (clk),
    .rst_n     (rst_n),
    .decode_en (decode_en),
    .ir        (ir),
    .rf_we     (wb_en && rd_write),
    .rf_wa     (ir[11:7]),
    .rf_wd     (alu_out),
    .a         (a),
    .b         (b),
    .imm       (imm)
  );

  // Instruction class and ALU result; anything not recognised leaves rd_write low (NOP).
  always_comb begin
    alu_res  = '0;
    rd_write = 1'b0;
    is_jal   = 1'b0;
    is_jalr  = 1'b0;
    br_cond  = 1'b0;
    case (opcode)
      OP_LUI:   begin alu_res = imm;      rd_write = 1'b1; end
      OP_AUIPC: begin alu_res = pc + imm; rd_write = 1'b1; end
      OP_IMM: begin
        rd_write = 1'b1;
        case (funct3)
          3'b000: alu_res = a + imm;
          3'b010: alu_res = {31'b0, $signed(a) < $signed(imm)};
          3'b100: alu_res = a ^ imm;
          3'b110: alu_res = a | imm;
          3'b111: alu_res = a & imm;
          3'b001: begin
            alu_res  = a << imm[4:0];
            rd_write = (funct7 == 7'b0000000);
          end
          3'b101: begin
            if (funct7 == 7'b0100000) alu_res = $signed(a) >>> imm[4:0];
            else                      alu_res = a >> imm[4:0];
            rd_write = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          end
          default: rd_write = 1'b0;
        endcase
      end
      OP_REG: begin
        rd_write = 1'b1;
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: alu_res = a + b;
          {7'b0100000, 3'b000}: alu_res = a - b;
          {7'b0000000, 3'b001}: alu_res = a << b[4:0];
          {7'b0000000, 3'b010}: alu_res = {31'b0, $signed(a) < $signed(b)};
          {7'b0000000, 3'b100}: alu_res = a ^ b;
          {7'b0000000, 3'b101}: alu_res = a >> b[4:0];
          {7'b0100000, 3'b101}: alu_res = $signed(a) >>> b[4:0];
          {7'b0000000, 3'b110}: alu_res = a | b;
          {7'b0000000, 3'b111}: alu_res = a & b;
          default:              rd_write = 1'b0;
        endcase
      end
      OP_JAL: begin
        alu_res  = pc_plus4;
        rd_write = 1'b1;
        is_jal   = 1'b1;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          alu_res  = pc_plus4;
          rd_write = 1'b1;
          is_jalr  = 1'b1;
        end
      end
`ifdef FARM_BRANCH_EN
      OP_BRANCH: begin
        case (funct3)
          3'b000:  br_cond = (a == b);
          3'b001:  br_cond = (a != b);
          default: br_cond = 1'b0;
        endcase
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out  <= '0;
      br_taken <= 1'b0;
    end else if (exec_en) begin
      alu_out  <= alu_res;
      br_taken <= br_cond;
    end
  end

  // A and imm still hold the decoded operands at WRITEBACK, so targets are formed here.
  always_comb begin
    pc_nxt = pc_plus4;
    if (is_jal)        pc_nxt = pc + imm;
    else if (is_jalr)  pc_nxt = (a + imm) & ~32'd1;
    else if (br_taken) pc_nxt = pc + imm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          ret_ad <= '0;
    else if (wb_en && (is_jal || is_jalr)) ret_ad <= pc_plus4;
  end
endmodule

// File: tb/tb_farm_top.sv
// Directed self-checking bench for farm_top: reset, sequencing, x0, jumps, branches, ALU, async reset.
module tb_farm_top;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ins, ret_ad;
  int          vectors = 0;
  int          miscompares = 0;

`ifdef FARM_BRANCH_EN
  localparam logic [31:0] BEQ_PC = 32'd16;
  localparam logic [31:0] BNE_PC = 32'd20;
`else
  localparam logic [31:0] BEQ_PC = 32'd12;
  localparam logic [31:0] BNE_PC = 32'd16;
`endif

  farm_top #(.IMEM_DEPTH(64), .RESET_PC(32'h0)) DUT (
    .clk    (clk),
    .rst_n  (rst_n),
    .ins    (ins),
    .ret_ad (ret_ad)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) DUT.farm_pmi.imem.mem[i] = 32'h0;
  endtask

  task automatic hold_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rf(input int i);
    return DUT.farm_dec.RF.regs[i];
  endfunction

  function automatic logic [31:0] st();
    return 32'(DUT.cg.state);
  endfunction

  function automatic logic [31:0] pc();
    return DUT.farm_fetch.iag.PC;
  endfunction

  initial begin
    logic [31:0] acc;

    // Reset values and basic sequencing
    clear_imem();
    DUT.farm_pmi.imem.mem[0] = 32'h00500093;
    DUT.farm_pmi.imem.mem[1] = 32'h00308113;
    DUT.farm_pmi.imem.mem[2] = 32'h002081b3;
    hold_reset();
    check("rst_state", st(), 32'd0);
    check("rst_pc", pc(), 32'd0);
    check("rst_ins", ins, 32'd0);
    check("rst_ret_ad", ret_ad, 32'd0);
    acc = '0;
    for (int i = 0; i < 32; i++) acc = acc | rf(i);
    check("rst_rf_or", acc, 32'd0);
    rst_n = 1'b1;
    step(1);
    check("fetch_ins", ins, 32'h00500093);
    check("fetch_state", st(), 32'd1);
    step(1);
    check("dec_state", st(), 32'd2);
    step(1);
    check("exe_state", st(), 32'd3);
    check("exe_pc_held", pc(), 32'd0);
    step(1);
    check("wb1_state", st(), 32'd0);
    check("wb1_pc", pc(), 32'd4);
    check("x1_addi", rf(1), 32'd5);
    step(4);
    check("wb2_pc", pc(), 32'd8);
    check("x2_addi", rf(2), 32'd8);
    step(4);
    check("wb3_pc", pc(), 32'd12);
    check("x3_add", rf(3), 32'd13);

    // x0 protection, then an all-zero word behaves as NOP
    clear_imem();
    DUT.farm_pmi.imem.mem[0] = 32'h00700013;
    hold_reset();
    rst_n = 1'b1;
    step(4);
    check("x0_zero", rf(0), 32'd0);
    check("x0_pc", pc(), 32'd4);
    step(4);
    check("nop_pc", pc(), 32'd8);
    check("nop_x0", rf(0), 32'd0);
    DUT.farm_dec.RF.dump(0, 1);

    // JAL / JALR link and targets
    clear_imem();
    DUT.farm_pmi.imem.mem[0] = 32'h008000ef;
    DUT.farm_pmi.imem.mem[2] = 32'h000082e7;
    hold_reset();
    rst_n = 1'b1;
    step(4);
    check("jal_pc", pc(), 32'd8);
    check("jal_x1", rf(1), 32'd4);
    check("jal_ret_ad", ret_ad, 32'd4);
    step(4);
    check("jalr_pc", pc(), 32'd4);
    check("jalr_ret_ad", ret_ad, 32'd12);
    check("jalr_x5", rf(5), 32'd12);

    // BEQ taken then BNE not taken (NOPs when branches are disabled)
    clear_imem();
    DUT.farm_pmi.imem.mem[0] = 32'h00100093;
    DUT.farm_pmi.imem.mem[1] = 32'h00100113;
    DUT.farm_pmi.imem.mem[2] = 32'h00208463;
    DUT.farm_pmi.imem.mem[3] = 32'h00209463;
    DUT.farm_pmi.imem.mem[4] = 32'h00209463;
    hold_reset();
    rst_n = 1'b1;
    step(8);
    check("br_setup_pc", pc(), 32'd8);
    step(4);
    check("beq_pc", pc(), BEQ_PC);
    step(4);
    check("bne_pc", pc(), BNE_PC);

    // ALU variety: lui, srai, sub, slt, auipc, xori, srl
    clear_imem();
    DUT.farm_pmi.imem.mem[0] = 32'h800000b7;
    DUT.farm_pmi.imem.mem[1] = 32'h4040d113;
    DUT.farm_pmi.imem.mem[2] = 32'h401101b3;
    DUT.farm_pmi.imem.mem[3] = 32'h00312233;
    DUT.farm_pmi.imem.mem[4] = 32'h00001297;
    DUT.farm_pmi.imem.mem[5] = 32'hfff24313;
    DUT.farm_pmi.imem.mem[6] = 32'h0040d3b3;
    hold_reset();
    rst_n = 1'b1;
    step(28);
    check("lui_x1", rf(1), 32'h80000000);
    check("srai_x2", rf(2), 32'hf8000000);
    check("sub_x3", rf(3), 32'h78000000);
    check("slt_x4", rf(4), 32'd1);
    check("auipc_x5", rf(5), 32'h00001010);
    check("xori_x6", rf(6), 32'hfffffffe);
    check("srl_x7", rf(7), 32'h40000000);
    check("alu_pc", pc(), 32'd28);

    // Asynchronous reset in the middle of EXECUTE
    clear_imem();
    DUT.farm_pmi.imem.mem[0] = 32'h00500093;
    DUT.farm_pmi.imem.mem[1] = 32'h00308113;
    hold_reset();
    rst_n = 1'b1;
    step(4);
    check("ar_pre_x1", rf(1), 32'd5);
    step(2);
    check("ar_pre_state", st(), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("ar_state", st(), 32'd0);
    check("ar_pc", pc(), 32'd0);
    check("ar_ins", ins, 32'd0);
    #4 rst_n = 1'b1;
    @(negedge clk);
    check("ar_x2_nowrite", rf(2), 32'd0);
    check("ar_x1_cleared", rf(1), 32'd0);
    step(4);
    check("ar_restart_pc", pc(), 32'd4);
    check("ar_restart_x1", rf(1), 32'd5);
    step(4);
    check("ar_restart_x2", rf(2), 32'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
